// File: rtl/lutram_seq_pkg.sv
// lutram_seq_pkg
//   Shared types and constants for the LUT-RAM pattern sequencer.
//   mode_e      : playback mode (loop, one-shot, ping-pong)
//   state_e     : sequencer FSM state (idle, playing)
//   DIR_UP/DOWN : ping-pong direction encoding
//   decode_mode : maps the raw 2-bit mode input onto mode_e (11 -> loop)
package lutram_seq_pkg;

  typedef enum logic [1:0] {
    LOOP     = 2'b00,
    ONESHOT  = 2'b01,
    PINGPONG = 2'b10
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // The unused encoding 11 behaves exactly like loop mode.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    mode_e m;
    case (raw)
      2'b01:   m = ONESHOT;
      2'b10:   m = PINGPONG;
      default: m = LOOP;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lutram_seq_mem.sv
// lutram_seq_mem
//   DEPTH x DATA_W pattern store: synchronous write, asynchronous read,
//   shaped so it maps onto distributed LUT-RAM (RAM16SDP).
//   clk     : clock
//   we      : write enable (one word per cycle)
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address (combinational read)
//   rd_data : word at rd_addr
//   Contents are deliberately not reset.
module lutram_seq_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lutram_pattern_sequencer.sv
// lutram_pattern_sequencer
//   Plays a programmable sequence of patterns from a 16-deep LUT-RAM onto
//   pat_out, stepping every max(period,1) cycles between first_addr and
//   last_addr in loop, one-shot or ping-pong mode. Host writes share the
//   single RAM slot with playback fetches; a fetch always wins.
//   clk, reset (sync, active-high)
//   wr_valid/wr_ready/wr_addr/wr_data : host pattern write handshake
//   start/stop                        : playback control pulses (stop wins)
//   mode/first_addr/last_addr/period  : config, sampled on start
//   pat_out/cur_addr                  : registered pattern and its address
//   busy                              : high while playing
//   done                              : one-cycle pulse when one-shot ends
module lutram_pattern_sequencer
  import lutram_seq_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int PRESC_W = 25,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [ADDR_W-1:0]  first_addr,
  input  logic [ADDR_W-1:0]  last_addr,
  input  logic [PRESC_W-1:0] period,
  output logic [DATA_W-1:0]  pat_out,
  output logic [ADDR_W-1:0]  cur_addr,
  output logic               busy,
  output logic               done
);

  state_e             state, state_next;
  mode_e              mode_r;
  logic [ADDR_W-1:0]  first_r, last_r;
  logic [PRESC_W-1:0] period_m1_r;
  logic [PRESC_W-1:0] step_cnt;
  logic               dir, dir_next;
  logic               fetch;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               done_next;
  logic               start_go;
  logic [PRESC_W-1:0] start_m1;
  logic [DATA_W-1:0]  rd_data;

  // Modulo-DEPTH stepping, written out so non power-of-two depths also wrap.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_dec(input logic [ADDR_W-1:0] a);
    return (a == '0) ? ADDR_W'(DEPTH - 1) : a - ADDR_W'(1);
  endfunction

  assign start_go = start & ~stop;
  // A period of 0 steps every cycle, same as 1.
  assign start_m1 = (period == '0) ? '0 : period - PRESC_W'(1);
  assign wr_ready = ~reset & ~fetch;
  assign busy     = (state == PLAY);

  lutram_seq_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we      (wr_valid & wr_ready),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (fetch_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, fetch decision and next address. The shown address
  // (cur_addr) is what the bound comparisons look at, so a step decision
  // is always made about the pattern currently on the bus.
  always_comb begin
    state_next = state;
    fetch      = 1'b0;
    fetch_addr = cur_addr;
    dir_next   = dir;
    done_next  = 1'b0;
    if (start_go) begin
      state_next = PLAY;
      fetch      = 1'b1;
      fetch_addr = first_addr;
      dir_next   = DIR_UP;
    end else if (state == PLAY) begin
      if (stop) begin
        state_next = IDLE;
      end else if (step_cnt == '0) begin
        case (mode_r)
          ONESHOT: begin
            if (cur_addr == last_r) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              fetch      = 1'b1;
              fetch_addr = addr_inc(cur_addr);
            end
          end
          PINGPONG: begin
            fetch = 1'b1;
            if (first_r == last_r) begin
              fetch_addr = cur_addr;
            end else if (dir == DIR_UP) begin
              if (cur_addr == last_r) begin
                dir_next   = DIR_DOWN;
                fetch_addr = addr_dec(cur_addr);
              end else begin
                fetch_addr = addr_inc(cur_addr);
              end
            end else begin
              if (cur_addr == first_r) begin
                dir_next   = DIR_UP;
                fetch_addr = addr_inc(cur_addr);
              end else begin
                fetch_addr = addr_dec(cur_addr);
              end
            end
          end
          default: begin
            fetch      = 1'b1;
            fetch_addr = (cur_addr == last_r) ? first_r : addr_inc(cur_addr);
          end
        endcase
      end
    end
  end

  // Config is captured only on an accepted start so a restart reloads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r      <= LOOP;
      first_r     <= '0;
      last_r      <= '0;
      period_m1_r <= '0;
    end else if (start_go) begin
      mode_r      <= decode_mode(mode);
      first_r     <= first_addr;
      last_r      <= last_addr;
      period_m1_r <= start_m1;
    end
  end

  // Step counter: reload on each fetch, count down to the next tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt <= '0;
    end else if (fetch) begin
      step_cnt <= start_go ? start_m1 : period_m1_r;
    end else if (state == PLAY && step_cnt != '0) begin
      step_cnt <= step_cnt - PRESC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_out  <= '0;
      cur_addr <= '0;
      done     <= 1'b0;
      dir      <= DIR_UP;
    end else begin
      if (fetch) begin
        pat_out  <= rd_data;
        cur_addr <= fetch_addr;
      end
      done <= done_next;
      dir  <= dir_next;
    end
  end

endmodule
